pulse_meter: RTL and testbench

Measurement stage that sits directly downstream of the programmable pulse generator. It samples the generator's output (or any external pulse train), measures high time and full period in clk cycles, and publishes each completed measurement with a one-cycle valid strobe. It is used for closed-loop self-check of the generator's tph/cycle settings and for bench readback.

---
 rtl/pulse_meter.sv | 121 ++++++++++++
 tb/tb_pulse_meter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Pulse train meter: synchronizes sig_in, measures high time and rise-to-rise
// period in clk cycles, and strobes meas_valid once per completed period.
module pulse_meter #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] tph_meas,
    output logic [CNT_W-1:0] t_meas,
    output logic             meas_valid,
    output logic             timeout,
    output logic [15:0]      meas_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    state_t                   state, state_nxt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     s_sync, s_prev, rise, fall, at_limit;
    logic [CNT_W-1:0]         cnt, cnt_nxt, hi_cnt, hi_nxt, tph_nxt, t_nxt;
    logic                     valid_nxt, to_nxt;
    logic [15:0]              count_nxt;

    assign s_sync   = sync_q[SYNC_STAGES-1];
    assign rise     = s_sync & ~s_prev;
    assign fall     = ~s_sync & s_prev;
    assign at_limit = (cnt == TIMEOUT_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            s_prev     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hi_cnt     <= '0;
            tph_meas   <= '0;
            t_meas     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            meas_count <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev     <= s_sync;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hi_cnt     <= hi_nxt;
            tph_meas   <= tph_nxt;
            t_meas     <= t_nxt;
            meas_valid <= valid_nxt;
            timeout    <= to_nxt;
            meas_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_cnt;
        tph_nxt   = tph_meas;
        t_nxt     = t_meas;
        valid_nxt = 1'b0;
        to_nxt    = timeout;
        count_nxt = meas_count;

        if (!meas_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            to_nxt    = 1'b0;
        end else begin
            unique case (state)
                IDLE: state_nxt = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_nxt = HIGH;
                        cnt_nxt   = ONE;
                    end
                end
                HIGH: begin
                    // an edge takes priority over a timeout in the same cycle
                    if (fall) begin
                        hi_nxt    = cnt;
                        cnt_nxt   = cnt + ONE;
                        state_nxt = LOW;
                    end else if (at_limit) begin
                        to_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WAIT_RISE;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        tph_nxt   = hi_cnt;
                        t_nxt     = cnt;
                        valid_nxt = 1'b1;
                        count_nxt = meas_count + 16'd1;
                        to_nxt    = 1'b0;
                        cnt_nxt   = ONE;
                        state_nxt = HIGH;
                    end else if (at_limit) begin
                        to_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WAIT_RISE;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: drives pulse trains on the falling edge and
// compares measurements against the high/low lengths it drove.
module tb_pulse_meter;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned TMO   = 30500;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             sig_in  = 1'b0;
    logic             meas_en = 1'b0;
    logic [CNT_W-1:0] tph_meas, t_meas;
    logic             meas_valid, timeout;
    logic [15:0]      meas_count;

    pulse_meter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .tph_meas   (tph_meas),
        .t_meas     (t_meas),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .meas_count (meas_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned      errors = 0, checks = 0;
    int unsigned      nvalid = 0, vcycle = 0, rise_cyc = 0, to_cyc = 0;
    logic             to_seen = 1'b0;
    logic [CNT_W-1:0] cap_tph = '0, cap_t = '0;

    // reference model of the period the next rise will close
    logic             armed = 1'b0;
    int unsigned      prev_hi = 0, prev_t = 0;
    logic [15:0]      exp_count = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int unsigned n, input logic v);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                nvalid++;
                vcycle  = cyc;
                cap_tph = tph_meas;
                cap_t   = t_meas;
            end
            if (timeout && !to_seen) begin
                to_seen = 1'b1;
                to_cyc  = cyc;
            end
            if (v && !sig_in) rise_cyc = cyc;
            sig_in = v;
        end
    endtask

    task automatic pulse(input int unsigned hi, input int unsigned lo);
        int unsigned v0;
        logic        expect_valid;
        v0 = nvalid;
        expect_valid = armed;
        run(hi, 1'b1);
        if (expect_valid) begin
            check("valid_n", 64'(nvalid - v0), 64'd1);
            check("tph", 64'(cap_tph), 64'(prev_hi));
            check("t", 64'(cap_t), 64'(prev_t));
            check("latency", 64'(vcycle - rise_cyc), 64'd3);
            exp_count++;
        end else begin
            check("no_valid", 64'(nvalid - v0), 64'd0);
        end
        check("count", 64'(meas_count), 64'(exp_count));
        run(lo, 1'b0);
        check("valid_low", 64'(nvalid - v0), expect_valid ? 64'd1 : 64'd0);
        armed   = 1'b1;
        prev_hi = hi;
        prev_t  = hi + lo;
    endtask

    initial begin
        int unsigned v0;

        repeat (3) @(negedge clk);
        check("rst_tph", 64'(tph_meas), 64'd0);
        check("rst_t", 64'(t_meas), 64'd0);
        check("rst_valid", 64'(meas_valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_count", 64'(meas_count), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            run(5, 1'b1);
            run(5, 1'b0);
        end
        check("idle_nvalid", 64'(nvalid), 64'd0);
        check("idle_tph", 64'(tph_meas), 64'd0);
        check("idle_t", 64'(t_meas), 64'd0);
        check("idle_count", 64'(meas_count), 64'd0);

        meas_en = 1'b1;
        run(10, 1'b0);
        repeat (3) pulse(250, 1750);

        pulse(10, 990);
        pulse(10, 990);
        pulse(990, 29313);

        to_seen = 1'b0;
        pulse(10, TMO);
        check("to_seen", 64'(to_seen), 64'd1);
        check("to_time", 64'(to_cyc - rise_cyc), 64'(TMO + 3));
        check("to_sticky", 64'(timeout), 64'd1);
        check("to_hold_tph", 64'(tph_meas), 64'd990);
        check("to_hold_t", 64'(t_meas), 64'd30303);
        armed = 1'b0;

        pulse(250, 1750);
        check("to_still", 64'(timeout), 64'd1);
        pulse(250, 1750);
        check("to_cleared", 64'(timeout), 64'd0);

        v0 = nvalid;
        run(100, 1'b1);
        check("ab_valid", 64'(nvalid - v0), 64'd1);
        check("ab_tph", 64'(cap_tph), 64'd250);
        check("ab_t", 64'(cap_t), 64'd2000);
        exp_count++;
        meas_en = 1'b0;
        run(20, 1'b1);
        check("ab_count", 64'(meas_count), 64'(exp_count));
        check("ab_hold_tph", 64'(tph_meas), 64'd250);
        check("ab_hold_t", 64'(t_meas), 64'd2000);
        meas_en = 1'b1;
        run(300, 1'b1);
        run(500, 1'b0);
        check("ab_novalid", 64'(nvalid - v0), 64'd1);
        check("ab_count2", 64'(meas_count), 64'(exp_count));
        armed = 1'b0;
        pulse(40, 60);
        pulse(30, 20);

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_tph", 64'(tph_meas), 64'd0);
        check("ar_t", 64'(t_meas), 64'd0);
        check("ar_valid", 64'(meas_valid), 64'd0);
        check("ar_timeout", 64'(timeout), 64'd0);
        check("ar_count", 64'(meas_count), 64'd0);
        exp_count = '0;
        armed     = 1'b0;
        sig_in    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run(10, 1'b0);
        pulse(30, 70);
        pulse(30, 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
